// File: rtl/tlcd_receiver.sv
// tlcd_receiver
// Panel-side responder for an HD44780-style character LCD write bus.
// The bus pins are oversampled on CLK through a synchronizer. Each falling edge
// of E is one transaction, which is decoded as an instruction or a data write.
// A 2x16 DDRAM image is exported as two packed 128-bit line buffers.

module tlcd_receiver #(
    parameter int SYNC_STAGES  = 2,
    parameter int EXEC_CYCLES  = 8,
    parameter int CLEAR_CYCLES = 80
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         TLCD_E,
    input  logic         TLCD_RS,
    input  logic         TLCD_RW,
    input  logic [7:0]   TLCD_DATA,
    output logic [127:0] TEXT_UPPER,
    output logic [127:0] TEXT_LOWER,
    output logic         DISP_ON,
    output logic [6:0]   CURSOR_ADDR,
    output logic         BUSY,
    output logic         CMD_VALID,
    output logic         PROTO_ERR
);

    localparam int CNT_MAX = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [127:0] BLANK_LINE = {16{8'h20}};

    typedef enum logic {IDLE, EXEC} state_t;

    // Bus bundle packing: {E, RS, RW, DATA[7:0]}
    logic [10:0] sync_q [SYNC_STAGES];
    logic [10:0] prev_q;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       upper_q, upper_d;
    logic [127:0]       lower_q, lower_d;
    logic               disp_q, disp_d;
    logic [6:0]         addr_q, addr_d;
    logic               incr_q, incr_d;
    logic               shift_q, shift_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               proto_err_q, proto_err_d;

    logic               fall;
    logic               bus_rs;
    logic               bus_rw;
    logic [7:0]         bus_data;
    logic [6:0]         col_base;

    // Address counter step with the two-line DDRAM wrap (0x27<->0x40, 0x67<->0x00)
    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        if (a == 7'h27)      return 7'h40;
        else if (a == 7'h67) return 7'h00;
        else                 return a + 7'd1;
    endfunction

    function automatic logic [6:0] addr_dec(input logic [6:0] a);
        if (a == 7'h00)      return 7'h67;
        else if (a == 7'h40) return 7'h27;
        else                 return a - 7'd1;
    endfunction

    // Synchronize the bus pins; prev_q keeps the previous synchronized sample
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= {TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // RS/RW/DATA come from the last sample that still had E high
    assign fall     = prev_q[10] & ~sync_q[SYNC_STAGES-1][10];
    assign bus_rs   = prev_q[9];
    assign bus_rw   = prev_q[8];
    assign bus_data = prev_q[7:0];

    // Next-state logic: busy countdown, strobe acceptance and command decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        upper_d     = upper_q;
        lower_d     = lower_q;
        disp_d      = disp_q;
        addr_d      = addr_q;
        incr_d      = incr_q;
        shift_d     = shift_q;
        cmd_valid_d = 1'b0;
        proto_err_d = 1'b0;
        col_base    = {~addr_q[3:0], 3'b000};

        case (state_q)
            EXEC: begin
                if (cnt_q <= CNT_W'(1)) state_d = IDLE;
                else                    cnt_d   = cnt_q - CNT_W'(1);
                if (fall) proto_err_d = 1'b1;
            end
            default: begin
                if (fall) begin
                    if (bus_rw || (!bus_rs && bus_data[7] && (bus_data[5:0] >= 6'h28))) begin
                        proto_err_d = 1'b1;
                    end else begin
                        cmd_valid_d = 1'b1;
                        state_d     = EXEC;
                        cnt_d       = CNT_W'(EXEC_CYCLES);
                        if (bus_rs) begin
                            if (addr_q[5:4] == 2'b00) begin
                                if (addr_q[6]) lower_d[col_base +: 8] = bus_data;
                                else           upper_d[col_base +: 8] = bus_data;
                            end
                            addr_d = incr_q ? addr_inc(addr_q) : addr_dec(addr_q);
                        end else begin
                            casez (bus_data)
                                8'b1???????: addr_d = bus_data[6:0];
                                8'b0001????: begin
                                    if (!bus_data[3])
                                        addr_d = bus_data[2] ? addr_inc(addr_q) : addr_dec(addr_q);
                                end
                                8'b00001???: disp_d = bus_data[2];
                                8'b000001??: begin
                                    incr_d  = bus_data[1];
                                    shift_d = bus_data[0];
                                end
                                8'b0000001?: begin
                                    addr_d = 7'h00;
                                    cnt_d  = CNT_W'(CLEAR_CYCLES);
                                end
                                8'b00000001: begin
                                    upper_d = BLANK_LINE;
                                    lower_d = BLANK_LINE;
                                    addr_d  = 7'h00;
                                    incr_d  = 1'b1;
                                    cnt_d   = CNT_W'(CLEAR_CYCLES);
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    // State register for the FSM and the display image
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            upper_q     <= BLANK_LINE;
            lower_q     <= BLANK_LINE;
            disp_q      <= 1'b0;
            addr_q      <= 7'h00;
            incr_q      <= 1'b1;
            shift_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            upper_q     <= upper_d;
            lower_q     <= lower_d;
            disp_q      <= disp_d;
            addr_q      <= addr_d;
            incr_q      <= incr_d;
            shift_q     <= shift_d;
            cmd_valid_q <= cmd_valid_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign TEXT_UPPER  = upper_q;
    assign TEXT_LOWER  = lower_q;
    assign DISP_ON     = disp_q;
    assign CURSOR_ADDR = addr_q;
    assign BUSY        = (state_q == EXEC);
    assign CMD_VALID   = cmd_valid_q;
    assign PROTO_ERR   = proto_err_q;

endmodule
